// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word and RAM handshake types plus the memory arbiter FSM state.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // RAM handshake as seen by the arbiter
  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    IACC = 2'b01,
    DACC = 2'b10
  } arb_state_t;

  // Bits needed to hold values 0..max inclusive
  function automatic int unsigned cnt_width(input int unsigned max);
    return (max < 2) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned Width = 3,
  parameter int unsigned Max   = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  localparam logic [Width-1:0] MaxVal = Width'(Max);

  logic [Width-1:0] count_q, count_d;

  // Next count: clear, saturating increment, or hold
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != MaxVal)) begin
      count_d = count_q + Width'(1);
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM port between instruction fetch and data access.
// Data wins by default; after DBURST_MAX data grants with a fetch pending the fetch is forced.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned DBURST_MAX = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output word_t             iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  word_t             dstore,
  output logic              dwait,
  output word_t             dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output word_t             ramstore,
  input  word_t             ramload,
  input  ramstate_t         ramstate,
  output logic              buserr
);

  localparam int unsigned      CntW     = cnt_width(DBURST_MAX);
  localparam logic [CntW-1:0]  BurstMax = CntW'(DBURST_MAX);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] iaddr_q, iaddr_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  word_t             dstore_q, dstore_d;
  logic              wr_q, wr_d;
  logic [CntW-1:0]   bcnt;

  logic d_req, grant_d, grant_i;
  logic i_abort, d_abort, i_done, d_done, i_err, d_err;
  logic bcnt_clr, bcnt_inc;

  // Arbitration, abort and completion decode
  always_comb begin
    d_req   = dREN | dWEN;
    grant_d = (state_q == IDLE) && d_req && (!iREN || (bcnt < BurstMax));
    grant_i = (state_q == IDLE) && !grant_d && iREN;
    // Owner withdrew or moved its address: drop the access without completing
    i_abort = (state_q == IACC) && (!iREN || (iaddr != iaddr_q));
    d_abort = (state_q == DACC) && (!d_req || (daddr != daddr_q));
    i_done  = (state_q == IACC) && !i_abort && (ramstate == ACCESS);
    d_done  = (state_q == DACC) && !d_abort && (ramstate == ACCESS);
    i_err   = (state_q == IACC) && !i_abort && (ramstate == ERROR);
    d_err   = (state_q == DACC) && !d_abort && (ramstate == ERROR);
    bcnt_clr = !iREN || i_done;
    bcnt_inc = d_done;
  end

  sat_counter #(
    .Width(CntW),
    .Max  (DBURST_MAX)
  ) u_bcnt (
    .clk_i  (CLK),
    .rst_ni (nRST),
    .clr_i  (bcnt_clr),
    .inc_i  (bcnt_inc),
    .count_o(bcnt)
  );

  // FSM state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = DACC;
        end else if (grant_i) begin
          state_d = IACC;
        end
      end
      IACC: begin
        if (i_abort || i_done || i_err) state_d = IDLE;
      end
      DACC: begin
        if (d_abort || d_done || d_err) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latches captured at grant time
  always_comb begin
    iaddr_d  = iaddr_q;
    daddr_d  = daddr_q;
    dstore_d = dstore_q;
    wr_d     = wr_q;
    if (grant_d) begin
      daddr_d  = daddr;
      dstore_d = dstore;
      wr_d     = dWEN;
    end else if (grant_i) begin
      iaddr_d = iaddr;
    end
  end

  // Request latch registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      iaddr_q  <= '0;
      daddr_q  <= '0;
      dstore_q <= '0;
      wr_q     <= 1'b0;
    end else begin
      iaddr_q  <= iaddr_d;
      daddr_q  <= daddr_d;
      dstore_q <= dstore_d;
      wr_q     <= wr_d;
    end
  end

  // Outputs: RAM side only from latches, waits from state and ramstate
  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    buserr   = 1'b0;
    unique case (state_q)
      IACC: begin
        ramREN  = 1'b1;
        ramaddr = iaddr_q;
        iwait   = !i_done;
        iload   = i_done ? ramload : '0;
        buserr  = i_err;
      end
      DACC: begin
        ramREN   = !wr_q;
        ramWEN   = wr_q;
        ramaddr  = daddr_q;
        ramstore = dstore_q;
        dwait    = !d_done;
        dload    = d_done ? ramload : '0;
        buserr   = d_err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios, then random traffic against a RAM model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic      CLK  = 1'b0;
  logic      nRST = 1'b0;
  logic      iREN = 1'b0;
  word_t     iaddr = '0;
  logic      iwait;
  word_t     iload;
  logic      dREN = 1'b0;
  logic      dWEN = 1'b0;
  word_t     daddr = '0;
  word_t     dstore = '0;
  logic      dwait;
  word_t     dload;
  logic      ramREN, ramWEN, buserr;
  word_t     ramaddr, ramstore, ramload;
  ramstate_t ramstate;

  // RAM side: directed code drives man_*, the random responder drives auto_*
  logic      auto_ram   = 1'b0;
  ramstate_t man_state  = FREE;
  ramstate_t auto_state = FREE;
  word_t     man_load   = '0;
  word_t     auto_load  = '0;
  assign ramstate = auto_ram ? auto_state : man_state;
  assign ramload  = auto_ram ? auto_load  : man_load;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic  wr;
    word_t data;
  } dexp_t;

  word_t iq[$];
  dexp_t dq[$];
  word_t ram_mem[word_t];
  word_t ref_mem[word_t];
  word_t ie;
  dexp_t de;

  always #5 CLK = ~CLK;

  mem_arbiter #(
    .DBURST_MAX(4),
    .ADDR_W    (32)
  ) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .iwait   (iwait),
    .iload   (iload),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .daddr   (daddr),
    .dstore  (dstore),
    .dwait   (dwait),
    .dload   (dload),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
    .ramstate(ramstate),
    .buserr  (buserr)
  );

  // Instruction region below 0x1000 is read-only content; data region initial content
  function automatic word_t imem(input word_t a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic word_t dinit(input word_t a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input word_t act, input word_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard monitor: pops an expectation whenever a wait line drops
  always @(negedge CLK) begin
    if (nRST) begin
      chk("buserr", word_t'(buserr), word_t'(ramstate == ERROR));
      chk("wait_exclusive", word_t'(!iwait && !dwait), 32'd0);
      if (!iwait) begin
        if (iq.size() == 0) begin
          chk("iload_unexpected", 32'd1, 32'd0);
        end else begin
          ie = iq.pop_front();
          chk("iload", iload, ie);
        end
      end
      if (!dwait) begin
        if (dq.size() == 0) begin
          chk("dload_unexpected", 32'd1, 32'd0);
        end else begin
          de = dq.pop_front();
          if (!de.wr) chk("dload", dload, de.data);
        end
      end
    end
  end

  // Random RAM responder: BUSY/ACCESS/ERROR per cycle, writes land on ACCESS
  always @(posedge CLK) begin
    #1;
    if (auto_ram) begin
      if (ramREN || ramWEN) begin
        int unsigned r;
        r = $urandom_range(0, 15);
        if (r == 0)     auto_state = ERROR;
        else if (r < 6) auto_state = BUSY;
        else            auto_state = ACCESS;
        if (ramaddr < 32'h1000) auto_load = imem(ramaddr);
        else auto_load = ram_mem.exists(ramaddr) ? ram_mem[ramaddr] : dinit(ramaddr);
        if (auto_state == ACCESS && ramWEN) ram_mem[ramaddr] = ramstore;
      end else begin
        auto_state = FREE;
        auto_load  = $urandom;
      end
    end
  end

  task automatic idrv(input int n);
    for (int k = 0; k < n; k++) begin
      word_t a;
      bit    done;
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      #2;
      a = word_t'($urandom_range(0, 1023)) << 2;
      iREN  = 1'b1;
      iaddr = a;
      iq.push_back(imem(a));
      done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
        @(negedge CLK);
        if (!iwait) done = 1'b1;
      end
      chk("ifetch_timeout", word_t'(done), 32'd1);
      @(posedge CLK);
      #2;
      iREN = 1'b0;
    end
  endtask

  task automatic ddrv(input int n);
    for (int k = 0; k < n; k++) begin
      word_t       a, st;
      int unsigned op;
      bit          done;
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      #2;
      a  = 32'h1000 + (word_t'($urandom_range(0, 7)) << 2);
      op = $urandom_range(0, 3);
      st = $urandom;
      daddr  = a;
      dstore = st;
      dREN   = (op != 2);
      dWEN   = (op >= 2);
      if (op >= 2) begin
        ref_mem[a] = st;
        dq.push_back('{wr: 1'b1, data: '0});
      end else begin
        dq.push_back('{wr: 1'b0, data: ref_mem.exists(a) ? ref_mem[a] : dinit(a)});
      end
      done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
        @(negedge CLK);
        if (!dwait) done = 1'b1;
      end
      chk("data_timeout", word_t'(done), 32'd1);
      @(posedge CLK);
      #2;
      dREN = 1'b0;
      dWEN = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with no requests
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    tick();
    chk("rst_iwait", word_t'(iwait), 32'd1);
    chk("rst_dwait", word_t'(dwait), 32'd1);
    chk("rst_ramREN", word_t'(ramREN), 32'd0);
    chk("rst_ramWEN", word_t'(ramWEN), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    chk("rst_iload", iload, 32'd0);
    chk("rst_dload", dload, 32'd0);
    chk("rst_buserr", word_t'(buserr), 32'd0);

    // Fetch with two BUSY cycles before ACCESS
    iREN  = 1'b1;
    iaddr = 32'h40;
    tick();
    chk("t2_c1_ramREN", word_t'(ramREN), 32'd1);
    chk("t2_c1_ramaddr", ramaddr, 32'h40);
    man_state = BUSY;
    tick();
    chk("t2_c2_ramREN", word_t'(ramREN), 32'd1);
    tick();
    man_state = ACCESS;
    man_load  = 32'h8C22_0004;
    iq.push_back(32'h8C22_0004);
    #1;
    chk("t2_c3_iwait", word_t'(iwait), 32'd0);
    chk("t2_c3_iload", iload, 32'h8C22_0004);
    tick();
    iREN      = 1'b0;
    man_state = FREE;
    chk("t2_idle_ramREN", word_t'(ramREN), 32'd0);

    // Simultaneous fetch and store: data first
    iREN   = 1'b1;
    iaddr  = 32'h40;
    dWEN   = 1'b1;
    daddr  = 32'h100;
    dstore = 32'hDEAD_BEEF;
    tick();
    chk("t3_ramWEN", word_t'(ramWEN), 32'd1);
    chk("t3_ramREN", word_t'(ramREN), 32'd0);
    chk("t3_ramaddr", ramaddr, 32'h100);
    chk("t3_ramstore", ramstore, 32'hDEAD_BEEF);
    man_state = ACCESS;
    dq.push_back('{wr: 1'b1, data: '0});
    #1;
    chk("t3_dwait", word_t'(dwait), 32'd0);
    tick();
    dWEN      = 1'b0;
    man_state = FREE;
    tick();
    chk("t3_fetch_ramREN", word_t'(ramREN), 32'd1);
    chk("t3_fetch_ramaddr", ramaddr, 32'h40);
    man_state = ACCESS;
    man_load  = imem(32'h40);
    iq.push_back(imem(32'h40));
    tick();
    iREN      = 1'b0;
    man_state = FREE;
    tick();

    // Back-to-back data reads with fetch pending: 4 data, then fetch, then data again
    iREN  = 1'b1;
    iaddr = 32'h40;
    dREN  = 1'b1;
    daddr = 32'h1000;
    for (int g = 0; g < 6; g++) begin
      tick();
      if (g == 4) begin
        chk("t4_grant_fetch", ramaddr, 32'h40);
        man_load = imem(32'h40);
        iq.push_back(man_load);
      end else begin
        chk("t4_grant_data", ramaddr, 32'h1000);
        man_load = 32'h5000_0000 + word_t'(g);
        dq.push_back('{wr: 1'b0, data: 32'h5000_0000 + word_t'(g)});
      end
      man_state = ACCESS;
      tick();
      man_state = FREE;
    end
    iREN = 1'b0;
    dREN = 1'b0;
    tick();

    // ERROR during a data access, then re-grant
    dREN  = 1'b1;
    daddr = 32'h1004;
    tick();
    man_state = ERROR;
    #1;
    chk("t5_buserr", word_t'(buserr), 32'd1);
    chk("t5_dwait", word_t'(dwait), 32'd1);
    tick();
    man_state = FREE;
    chk("t5_idle_buserr", word_t'(buserr), 32'd0);
    chk("t5_idle_ramREN", word_t'(ramREN), 32'd0);
    tick();
    chk("t5_regrant_ramaddr", ramaddr, 32'h1004);
    man_state = ACCESS;
    man_load  = 32'hCAFE_0005;
    dq.push_back('{wr: 1'b0, data: 32'hCAFE_0005});
    tick();
    dREN      = 1'b0;
    man_state = FREE;
    tick();

    // Address change mid-fetch aborts and re-grants at the new address
    iREN  = 1'b1;
    iaddr = 32'h40;
    tick();
    chk("t6_first_ramaddr", ramaddr, 32'h40);
    man_state = BUSY;
    iaddr     = 32'h80;
    #1;
    chk("t6_abort_iwait", word_t'(iwait), 32'd1);
    tick();
    chk("t6_abort_ramREN", word_t'(ramREN), 32'd0);
    tick();
    chk("t6_regrant_ramaddr", ramaddr, 32'h80);
    man_state = ACCESS;
    man_load  = imem(32'h80);
    iq.push_back(imem(32'h80));
    tick();
    iREN      = 1'b0;
    man_state = FREE;
    tick();

    // Reset mid data access drops enables immediately
    dREN  = 1'b1;
    daddr = 32'h1008;
    tick();
    chk("t6b_ramREN", word_t'(ramREN), 32'd1);
    man_state = BUSY;
    #2;
    nRST = 1'b0;
    #1;
    chk("t6b_rst_ramREN", word_t'(ramREN), 32'd0);
    chk("t6b_rst_ramWEN", word_t'(ramWEN), 32'd0);
    chk("t6b_rst_dwait", word_t'(dwait), 32'd1);
    dREN      = 1'b0;
    man_state = FREE;
    @(negedge CLK);
    #1;
    nRST = 1'b1;
    tick();
    chk("t6b_post_ramREN", word_t'(ramREN), 32'd0);

    // Random concurrent traffic
    auto_ram = 1'b1;
    fork
      idrv(120);
      ddrv(120);
    join
    repeat (3) tick();
    auto_ram = 1'b0;
    chk("iq_drained", word_t'(iq.size()), 32'd0);
    chk("dq_drained", word_t'(dq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
